reg_file_mp: RTL

Parametrised multi-port register file with a per-register busy scoreboard, successor to the single-write, two-read CPU register file. It sits between decode (read ports, issue) and writeback (two write ports), supplying operands and hazard status in the same cycle. Storage, write arbitration and scoreboard update are synchronous to `clk`; reads are combinational.

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_scoreboard.sv | 66 ++++++
 rtl/reg_file_mp.sv | 113 +++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package reg_file_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  // A write is kept unless it targets the hard-wired zero register.
  function automatic logic addr_writable(input logic [31:0] addr, input logic zero_reg);
    return !(zero_reg && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy scoreboard: issue sets, flush/writeback clear, and
// a raw busy lookup for every read port.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = DEF_NUM_RD,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  output logic [NUM_RD-1:0]        rd_busy_raw
);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [NUM_RD-1:0]   busy_rd_s;

  // Next busy state: a new producer beats flush, flush beats writeback.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int r = 0; r < NUM_REGS; r++) begin
      if ((ZERO_REG != 0) && (r == 0)) begin
        busy_nxt_s[r] = 1'b0;
      end else if (iss_en && (iss_addr == ADDR_W'(r))) begin
        busy_nxt_s[r] = 1'b1;
      end else if (flush) begin
        busy_nxt_s[r] = 1'b0;
      end else if ((wr0_en && (wr0_addr == ADDR_W'(r))) ||
                   (wr1_en && (wr1_addr == ADDR_W'(r)))) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Raw busy lookup per read port.
  always_comb begin
    busy_rd_s = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      busy_rd_s[i] = busy_r[rd_addr[i*ADDR_W +: ADDR_W]];
    end
  end

  assign rd_busy_raw = busy_rd_s;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports (port 1 wins on conflict),
// NUM_RD combinational read ports and a busy scoreboard.
// Optional write-through forwarding: define REG_FILE_BYPASS_EN.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = DEF_NUM_RD,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush
);

  logic [DATA_W-1:0]        mem_r [NUM_REGS];
  logic                     wr0_ok_s;
  logic                     wr1_ok_s;
  logic [NUM_RD*DATA_W-1:0] rd_data_s;
  logic [NUM_RD-1:0]        busy_raw_s;

  assign wr0_ok_s = wr0_en && addr_writable(32'(wr0_addr), ZERO_REG != 0);
  assign wr1_ok_s = wr1_en && addr_writable(32'(wr1_addr), ZERO_REG != 0);

  // Storage: port 1 is written last so it wins a same-address conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem_r[r] <= '0;
      end
    end else begin
      if (wr0_ok_s) begin
        mem_r[wr0_addr] <= wr0_data;
      end
      if (wr1_ok_s) begin
        mem_r[wr1_addr] <= wr1_data;
      end
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic [NUM_RD-1:0] byp0_s;
  logic [NUM_RD-1:0] byp1_s;

  // Forwarding matches; suppressed in reset so reads stay zero there.
  always_comb begin
    byp0_s = '0;
    byp1_s = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      byp0_s[i] = rst_n && wr0_ok_s && (wr0_addr == rd_addr[i*ADDR_W +: ADDR_W]);
      byp1_s[i] = rst_n && wr1_ok_s && (wr1_addr == rd_addr[i*ADDR_W +: ADDR_W]);
    end
  end
`endif

  // Read muxes: zero register, then forwarded data, then stored value.
  always_comb begin
    rd_data_s = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if ((ZERO_REG != 0) && (rd_addr[i*ADDR_W +: ADDR_W] == '0)) begin
        rd_data_s[i*DATA_W +: DATA_W] = '0;
`ifdef REG_FILE_BYPASS_EN
      end else if (byp1_s[i]) begin
        rd_data_s[i*DATA_W +: DATA_W] = wr1_data;
      end else if (byp0_s[i]) begin
        rd_data_s[i*DATA_W +: DATA_W] = wr0_data;
`endif
      end else begin
        rd_data_s[i*DATA_W +: DATA_W] = mem_r[rd_addr[i*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign rd_data = rd_data_s;

  reg_file_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr     (rd_addr),
    .iss_en      (iss_en),
    .iss_addr    (iss_addr),
    .flush       (flush),
    .wr0_en      (wr0_en),
    .wr0_addr    (wr0_addr),
    .wr1_en      (wr1_en),
    .wr1_addr    (wr1_addr),
    .rd_busy_raw (busy_raw_s)
  );

`ifdef REG_FILE_BYPASS_EN
  assign rd_busy = busy_raw_s & ~(byp0_s | byp1_s);
`else
  assign rd_busy = busy_raw_s;
`endif

endmodule
